// File: rtl/nmr_pck_pkg.sv
// Shared types and constants for the NMR acquisition packetizer.
// Holds the FSM state encoding, the sts field layout and the drop counter helper.
package nmr_pck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pck_state_e;

    localparam int STS_STATE_LSB = 0;
    localparam int STS_STATE_MSB = 1;
    localparam int STS_OVF_BIT   = 2;
    localparam int STS_ABORT_BIT = 3;
    localparam int DROP_CNT_W    = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] r;
        if (v == {DROP_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pck_sync_fifo.sv
// Small synchronous FIFO with flop storage and registered full/empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module pck_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_pck,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    localparam ptr_t PTR_ONE  = ptr_t'(1'b1);
    localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
    localparam cnt_t CNT_ZERO = cnt_t'(1'b0);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_q, full_d, empty_q, empty_d;
    logic wr_en_s, rd_en_s;

    // Next pointers, occupancy and flags
    always_comb begin
        rd_en_s  = pop && !empty_q;
        wr_en_s  = push && (!full_q || rd_en_s);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_pck) begin
            wr_ptr_q <= ptr_t'(1'b0);
            rd_ptr_q <= ptr_t'(1'b0);
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/nmr_acq_packetizer.sv
// Turns the free-running ADC sample stream into nb_of_sample AXI4-Stream beats,
// framing a packet with tlast every `size` samples; overflowing samples are dropped.
module nmr_acq_packetizer
    import nmr_pck_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_pck,
    input  logic                  en_acq,
    input  logic [CNT_WIDTH-1:0]  size,
    input  logic [CNT_WIDTH-1:0]  nb_of_sample,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  sample_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  done,
    output logic [31:0]           sts
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
    localparam cnt_t CNT_ZERO = cnt_t'(1'b0);

    pck_state_e state_q, state_d;
    cnt_t size_q, size_d, nb_q, nb_d, sample_cnt_q, sample_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic overflow_q, overflow_d, aborted_q, aborted_d, done_q, done_d;

    logic                  fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [DATA_WIDTH:0]   fifo_wdata_s, fifo_rdata_s;
    logic                  accept_s, last_pkt_s, last_tot_s;

    pck_sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_pck (rst_pck),
        .push    (fifo_push_s),
        .wdata   (fifo_wdata_s),
        .pop     (fifo_pop_s),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // A full FIFO still accepts when the head leaves in the same cycle
    assign fifo_pop_s = m_axis_tvalid && m_axis_tready;
    assign accept_s   = s_axis_tvalid && (!fifo_full_s || fifo_pop_s);
    assign last_pkt_s = (size_q != CNT_ZERO) && ((pkt_cnt_q + CNT_ONE) == size_q);
    assign last_tot_s = (sample_cnt_q + CNT_ONE) == nb_q;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_pck) begin
            state_q      <= ST_IDLE;
            size_q       <= CNT_ZERO;
            nb_q         <= CNT_ZERO;
            sample_cnt_q <= CNT_ZERO;
            pkt_cnt_q    <= CNT_ZERO;
            drop_cnt_q   <= 16'd0;
            overflow_q   <= 1'b0;
            aborted_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            nb_q         <= nb_d;
            sample_cnt_q <= sample_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            aborted_q    <= aborted_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_acq) begin
                    state_d = (nb_of_sample == CNT_ZERO) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en_acq) begin
                    state_d = ST_DRAIN;
                end else if (accept_s && last_tot_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!en_acq) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run latching, counters, sticky flags and FIFO push
    always_comb begin
        size_d       = size_q;
        nb_d         = nb_q;
        sample_cnt_d = sample_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        aborted_d    = aborted_q;
        fifo_push_s  = 1'b0;
        fifo_wdata_s = {(last_pkt_s || last_tot_s), s_axis_tdata};
        done_d       = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (en_acq) begin
                    size_d       = size;
                    nb_d         = nb_of_sample;
                    sample_cnt_d = CNT_ZERO;
                    pkt_cnt_d    = CNT_ZERO;
                    drop_cnt_d   = 16'd0;
                    overflow_d   = 1'b0;
                    aborted_d    = 1'b0;
                end else begin
                    size_d = size_q;
                end
            end
            ST_RUN: begin
                if (!en_acq) begin
                    aborted_d = 1'b1;
                end else if (accept_s) begin
                    fifo_push_s  = 1'b1;
                    sample_cnt_d = sample_cnt_q + CNT_ONE;
                    pkt_cnt_d    = last_pkt_s ? CNT_ZERO : (pkt_cnt_q + CNT_ONE);
                end else if (s_axis_tvalid) begin
                    drop_cnt_d = sat_inc_drop(drop_cnt_q);
                    overflow_d = 1'b1;
                end else begin
                    fifo_push_s = 1'b0;
                end
            end
            default: fifo_push_s = 1'b0;
        endcase
    end

    // Outputs straight from registers
    always_comb begin
        sts                              = 32'd0;
        sts[STS_STATE_MSB:STS_STATE_LSB] = state_q;
        sts[STS_OVF_BIT]                 = overflow_q;
        sts[STS_ABORT_BIT]               = aborted_q;
        m_axis_tvalid                    = !fifo_empty_s;
        m_axis_tdata                     = fifo_rdata_s[DATA_WIDTH-1:0];
        m_axis_tlast                     = !fifo_empty_s && fifo_rdata_s[DATA_WIDTH];
        sample_cnt                       = sample_cnt_q;
        drop_cnt                         = drop_cnt_q;
        done                             = done_q;
    end

endmodule

// File: tb/tb_nmr_acq_packetizer.sv
// Directed bench for nmr_acq_packetizer: each scenario drives a run and checks
// beats, counters and status against hand-computed values.
module tb_nmr_acq_packetizer;
    logic        clk = 1'b0;
    logic        rst_pck = 1'b0;
    logic        en_acq = 1'b0;
    logic [31:0] size = 32'd0;
    logic [31:0] nb_of_sample = 32'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [31:0] sample_cnt;
    logic [15:0] drop_cnt;
    logic        done;
    logic [31:0] sts;

    int total = 0;
    int bad = 0;
    logic [31:0] beat_data [$];
    logic        beat_last [$];
    logic [31:0] exp_data [$];
    logic        exp_last [$];
    logic        tvalid_seen = 1'b0;

    nmr_acq_packetizer dut (
        .clk           (clk),
        .rst_pck       (rst_pck),
        .en_acq        (en_acq),
        .size          (size),
        .nb_of_sample  (nb_of_sample),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .sample_cnt    (sample_cnt),
        .drop_cnt      (drop_cnt),
        .done          (done),
        .sts           (sts)
    );

    always #5 clk = ~clk;

    // Record every beat that will transfer at the coming rising edge
    always @(negedge clk) begin
        if (m_axis_tvalid) tvalid_seen = 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the ADC counter ramps by one every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        s_axis_tdata = s_axis_tdata + 32'd1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic add_exp(input logic [31:0] d, input logic l);
        exp_data.push_back(d);
        exp_last.push_back(l);
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_nbeats"}, 32'(beat_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < beat_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), beat_data[i], exp_data[i]);
                check($sformatf("%s_last%0d", tag, i), {31'd0, beat_last[i]}, {31'd0, exp_last[i]});
            end
        end
    endtask

    task automatic start_run(input logic [31:0] sz, input logic [31:0] nb, input logic [31:0] d0);
        beat_data.delete();
        beat_last.delete();
        exp_data.delete();
        exp_last.delete();
        tvalid_seen   = 1'b0;
        size          = sz;
        nb_of_sample  = nb;
        s_axis_tdata  = d0;
        s_axis_tvalid = 1'b1;
        en_acq        = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_sample_cnt", sample_cnt, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sts", sts, 32'd0);
        rst_pck = 1'b1;
        m_axis_tready = 1'b1;
        tick();

        // size=4, nb=8: tlast on beats 4 and 8
        start_run(32'd4, 32'd8, 32'd100);
        for (int i = 0; i < 8; i++) add_exp(32'd101 + 32'(i), (i == 3) || (i == 7));
        wait_done("t1", 40);
        compare_beats("t1");
        check("t1_sample_cnt", sample_cnt, 32'd8);
        check("t1_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("t1_sts", sts, 32'd3);
        en_acq = 1'b0;
        tick();
        check("t1_idle_sts", sts, 32'd0);
        check("t1_idle_done", {31'd0, done}, 32'd0);

        // size=0, nb=5: single packet
        start_run(32'd0, 32'd5, 32'd200);
        for (int i = 0; i < 5; i++) add_exp(32'd201 + 32'(i), i == 4);
        wait_done("t2", 40);
        compare_beats("t2");
        check("t2_sample_cnt", sample_cnt, 32'd5);
        en_acq = 1'b0;
        tick();

        // size=16, nb=16 with tready low for the first 10 RUN cycles
        m_axis_tready = 1'b0;
        start_run(32'd16, 32'd16, 32'd300);
        tick();
        repeat (10) tick();
        check("t3_drop_mid", {16'd0, drop_cnt}, 32'd6);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) add_exp(32'd301 + 32'(i), 1'b0);
        for (int i = 0; i < 12; i++) add_exp(32'd311 + 32'(i), i == 11);
        wait_done("t3", 60);
        compare_beats("t3");
        check("t3_drop_cnt", {16'd0, drop_cnt}, 32'd6);
        check("t3_sample_cnt", sample_cnt, 32'd16);
        check("t3_sts", sts, 32'd7);
        en_acq = 1'b0;
        tick();
        check("t3_idle_sts", sts, 32'd4);

        // size=8, nb=100, abort after 3 samples accepted
        start_run(32'd8, 32'd100, 32'd400);
        repeat (4) tick();
        en_acq = 1'b0;
        for (int i = 0; i < 3; i++) add_exp(32'd401 + 32'(i), 1'b0);
        wait_done("t4", 20);
        check("t4_sts", sts, 32'd11);
        check("t4_sample_cnt", sample_cnt, 32'd3);
        tick();
        compare_beats("t4");
        check("t4_idle_sts", sts, 32'd8);
        check("t4_idle_done", {31'd0, done}, 32'd0);

        // nb=0: no beats, done within 3 cycles
        start_run(32'd4, 32'd0, 32'd500);
        wait_done("t5", 3);
        check("t5_no_tvalid", {31'd0, tvalid_seen}, 32'd0);
        check("t5_sts", sts, 32'd3);
        en_acq = 1'b0;
        tick();

        // Reset mid-RUN with 3 entries held, then a fresh short run
        m_axis_tready = 1'b0;
        start_run(32'd8, 32'd100, 32'd600);
        repeat (4) tick();
        check("t6_pre_cnt", sample_cnt, 32'd3);
        rst_pck = 1'b0;
        tick();
        check("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("t6_rst_sample_cnt", sample_cnt, 32'd0);
        check("t6_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_sts", sts, 32'd0);
        rst_pck = 1'b1;
        en_acq = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check("t6_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        start_run(32'd2, 32'd2, 32'd700);
        add_exp(32'd701, 1'b0);
        add_exp(32'd702, 1'b1);
        wait_done("t6", 20);
        compare_beats("t6");
        check("t6_sample_cnt", sample_cnt, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
